// File: rtl/button_repeat_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : button_repeat_ctrl
//  Brief    : Synchronises and debounces two raw push-buttons, arbitrates
//             between them and emits one-cycle inc/dec command pulses with
//             hold-to-repeat behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module button_repeat_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int REPEAT_CYCLES   = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_down,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic repeating,
    output logic locked
);

    localparam int DB_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REPEAT_LAST = TMR_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HOLD    = 2'd1,
        S_REPEAT  = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Bit 0 = up button, bit 1 = down button
    logic [1:0] raw;
    logic [1:0] s1_q;
    logic [1:0] s2_q;
    logic [1:0] db_q;

    assign raw = {btn_down, btn_up};

    generate
        for (genvar b = 0; b < 2; b++) begin : g_btn
            logic [DB_W-1:0] cnt_q;

            // Two-flop synchroniser followed by a counter that flips the
            // debounced level once the input has disagreed for DEBOUNCE_CYCLES
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    s1_q[b] <= 1'b0;
                    s2_q[b] <= 1'b0;
                    db_q[b] <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    s1_q[b] <= raw[b];
                    s2_q[b] <= s1_q[b];
                    if (s2_q[b] != db_q[b]) begin
                        if (cnt_q == DB_LAST) begin
                            db_q[b] <= ~db_q[b];
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
            end
        end
    endgenerate

    logic db_up;
    logic db_down;
    assign db_up   = db_q[0];
    assign db_down = db_q[1];

    state_t             state_q, state_d;
    dir_t               dir_q, dir_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               inc_q, inc_d;
    logic               dec_q, dec_d;
    logic               act;
    logic               oth;
    logic [TMR_W-1:0]   limit;

    // Control state, direction, repeat timer and registered pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            dir_q   <= DIR_UP;
            timer_q <= '0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            timer_q <= timer_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
        end
    end

    // Next-state logic; conflict beats release, release beats timer expiry
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        timer_d = timer_q;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        act     = (dir_q == DIR_UP) ? db_up   : db_down;
        oth     = (dir_q == DIR_UP) ? db_down : db_up;
        limit   = (state_q == S_HOLD) ? HOLD_LAST : REPEAT_LAST;

        case (state_q)
            S_IDLE: begin
                if (db_up && db_down) begin
                    state_d = S_LOCKOUT;
                    timer_d = '0;
                end else if (db_up) begin
                    inc_d   = 1'b1;
                    dir_d   = DIR_UP;
                    timer_d = '0;
                    state_d = S_HOLD;
                end else if (db_down) begin
                    dec_d   = 1'b1;
                    dir_d   = DIR_DOWN;
                    timer_d = '0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD, S_REPEAT: begin
                if (oth) begin
                    state_d = S_LOCKOUT;
                    timer_d = '0;
                end else if (!act) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else if (timer_q == limit) begin
                    inc_d   = (dir_q == DIR_UP);
                    dec_d   = (dir_q == DIR_DOWN);
                    timer_d = '0;
                    state_d = S_REPEAT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_LOCKOUT: begin
                if (!db_up && !db_down) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    assign inc_pulse = inc_q;
    assign dec_pulse = dec_q;
    assign repeating = (state_q == S_REPEAT);
    assign locked    = (state_q == S_LOCKOUT);

endmodule
`default_nettype wire

// File: tb/tb_button_repeat_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_repeat_ctrl
//  Brief    : Directed self-checking bench for button_repeat_ctrl using the
//             default parameters (D=4, H=8, R=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_button_repeat_ctrl;

    logic clk;
    logic reset;
    logic btn_up;
    logic btn_down;
    logic inc_pulse;
    logic dec_pulse;
    logic repeating;
    logic locked;

    int tests = 0;
    int fails = 0;

    // Edge index relative to the latest stimulus origin (edge 0)
    int rel = 0;
    int inc_edges[$];
    int dec_edges[$];
    bit rep_log[0:127];
    bit lock_log[0:127];

    button_repeat_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (8),
        .REPEAT_CYCLES  (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .inc_pulse(inc_pulse),
        .dec_pulse(dec_pulse),
        .repeating(repeating),
        .locked   (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, sample 1 time unit later and log outputs
    task automatic step();
        @(posedge clk);
        #1;
        if (inc_pulse === 1'b1) inc_edges.push_back(rel);
        if (dec_pulse === 1'b1) dec_edges.push_back(rel);
        if (rel < 128) begin
            rep_log[rel]  = repeating;
            lock_log[rel] = locked;
        end
        if (inc_pulse === 1'b1 && dec_pulse === 1'b1)
            chk("pulse_exclusive", 1, 0);
        rel++;
    endtask

    task automatic run_to(input int e);
        while (rel <= e) step();
    endtask

    task automatic start();
        inc_edges.delete();
        dec_edges.delete();
        for (int i = 0; i < 128; i++) begin
            rep_log[i]  = 1'b0;
            lock_log[i] = 1'b0;
        end
        rel = 0;
    endtask

    function automatic int q_at(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    initial begin
        reset    = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        start();
        run_to(2);

        // Reset state
        chk("rst_inc", int'(inc_pulse), 0);
        chk("rst_dec", int'(dec_pulse), 0);
        chk("rst_rep", int'(repeating), 0);
        chk("rst_lock", int'(locked), 0);
        reset = 1'b1;
        run_to(5);

        // 1. Bounce: high runs of 1, 2, 3 cycles never reach the debounce count
        start();
        btn_up = 1'b1; run_to(0);
        btn_up = 1'b0; run_to(1);
        btn_up = 1'b1; run_to(3);
        btn_up = 1'b0; run_to(4);
        btn_up = 1'b1; run_to(7);
        btn_up = 1'b0; run_to(22);
        chk("bounce_inc", inc_edges.size(), 0);
        chk("bounce_dec", dec_edges.size(), 0);
        chk("bounce_rep", int'(repeating), 0);
        chk("bounce_lock", int'(locked), 0);

        // 2. Short press: one pulse at edge 6, edge-14 expiry suppressed
        start();
        btn_up = 1'b1; run_to(7);
        btn_up = 1'b0; run_to(22);
        chk("short_cnt", inc_edges.size(), 1);
        chk("short_edge", q_at(inc_edges, 0), 6);
        chk("short_dec", dec_edges.size(), 0);
        chk("short_rep14", int'(rep_log[14]), 0);

        // 3. Long hold: pulses at 6, 14, 17, ..., 44
        start();
        btn_up = 1'b1; run_to(39);
        btn_up = 1'b0; run_to(55);
        chk("long_cnt", inc_edges.size(), 12);
        for (int k = 0; k < 12; k++)
            chk($sformatf("long_edge%0d", k), q_at(inc_edges, k), (k == 0) ? 6 : 14 + 3 * (k - 1));
        chk("long_dec", dec_edges.size(), 0);
        chk("long_rep13", int'(rep_log[13]), 0);
        chk("long_rep14", int'(rep_log[14]), 1);
        chk("long_rep45", int'(rep_log[45]), 1);
        chk("long_rep46", int'(rep_log[46]), 0);

        // 4. Conflict: down pressed while up repeats -> lockout
        start();
        btn_up = 1'b1; run_to(19);
        btn_down = 1'b1; run_to(35);
        chk("conf_cnt", inc_edges.size(), 5);
        chk("conf_last", q_at(inc_edges, 4), 23);
        chk("conf_dec", dec_edges.size(), 0);
        chk("conf_lock25", int'(lock_log[25]), 0);
        chk("conf_lock26", int'(lock_log[26]), 1);
        chk("conf_rep26", int'(rep_log[26]), 0);
        btn_up = 1'b0; btn_down = 1'b0; run_to(50);
        chk("conf_lock41", int'(lock_log[41]), 1);
        chk("conf_lock42", int'(lock_log[42]), 0);
        chk("conf_inc_after", inc_edges.size(), 5);
        start();
        btn_down = 1'b1; run_to(7);
        btn_down = 1'b0; run_to(22);
        chk("down_cnt", dec_edges.size(), 1);
        chk("down_edge", q_at(dec_edges, 0), 6);
        chk("down_inc", inc_edges.size(), 0);

        // 5. Simultaneous press from IDLE -> lockout, no pulses
        start();
        btn_up = 1'b1; btn_down = 1'b1; run_to(11);
        btn_up = 1'b0; btn_down = 1'b0; run_to(25);
        chk("sim_inc", inc_edges.size(), 0);
        chk("sim_dec", dec_edges.size(), 0);
        chk("sim_lock5", int'(lock_log[5]), 0);
        chk("sim_lock6", int'(lock_log[6]), 1);
        chk("sim_lock17", int'(lock_log[17]), 1);
        chk("sim_lock18", int'(lock_log[18]), 0);

        // 6. Reset during REPEAT with the button still held
        start();
        btn_up = 1'b1; run_to(14);
        chk("rr_pulse14", int'(inc_pulse), 1);
        chk("rr_rep14", int'(repeating), 1);
        reset = 1'b0;
        #1;
        chk("rr_async_inc", int'(inc_pulse), 0);
        chk("rr_async_rep", int'(repeating), 0);
        chk("rr_async_lock", int'(locked), 0);
        step();
        step();
        reset = 1'b1;
        start();
        run_to(20);
        chk("rr_cnt", inc_edges.size(), 4);
        chk("rr_e0", q_at(inc_edges, 0), 6);
        chk("rr_e1", q_at(inc_edges, 1), 14);
        chk("rr_e2", q_at(inc_edges, 2), 17);
        chk("rr_e3", q_at(inc_edges, 3), 20);
        chk("rr_rep20", int'(rep_log[20]), 1);
        btn_up = 1'b0;
        run_to(30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_repeat_ctrl.md
Name: button_repeat_ctrl

Overview:
Front-end controller that sequences the up/down counter on the Basys3 board from raw push-buttons. It synchronises and debounces btn_up/btn_down, arbitrates between them, and issues single-cycle inc/dec command pulses. Pulses repeat automatically while a button is held. The counter datapath consumes inc_pulse/dec_pulse directly and needs no press-tracking of its own.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised input must differ from the debounced level before the level flips (>=2)
HOLD_CYCLES, 8, cycles from first pulse to first auto-repeat pulse (>=2)
REPEAT_CYCLES, 3, cycles between auto-repeat pulses (>=2)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset; 0 = reset asserted
btn_up  input  1  raw up button, asynchronous, bouncy
btn_down  input  1  raw down button, asynchronous, bouncy
inc_pulse  output  1  registered one-cycle increment command
dec_pulse  output  1  registered one-cycle decrement command
repeating  output  1  high while in REPEAT state
locked  output  1  high while in LOCKOUT state

Behaviour:
- Reset (reset=0): asynchronously clears all registers. Sync FFs=0, debounced levels db_up/db_down=0, debounce counters=0, timer=0, state=IDLE, dir=UP. All outputs are 0.
- Sync: two-FF synchroniser per button; s2 is the synchronised value.
- Debounce, per button: at each edge where s2 != db, the counter increments. When the count reaches DEBOUNCE_CYCLES, db toggles and the counter clears. Any edge where s2 == db clears the counter.
- Latency: raw change stable before edge 0 -> db changes at edge DEBOUNCE_CYCLES+1 -> pulse registered at edge DEBOUNCE_CYCLES+2.
- Pulses: inc_pulse and dec_pulse are registered, high for exactly one cycle, and never both high.
- FSM states: IDLE, HOLD, REPEAT, LOCKOUT. Register dir = UP/DOWN. Let act = db of dir, oth = db of the other button.
- IDLE:
  - db_up & db_down -> LOCKOUT, no pulse.
  - db_up only -> pulse inc, dir=UP, timer=0, go HOLD.
  - db_down only -> pulse dec, dir=DOWN, timer=0, go HOLD.
- HOLD, checked in priority order:
  - oth=1 -> LOCKOUT, no pulse.
  - act=0 -> IDLE, no pulse.
  - timer==HOLD_CYCLES-1 -> pulse dir, timer=0, go REPEAT.
  - otherwise timer++.
- REPEAT: same priority order as HOLD, using REPEAT_CYCLES; pulse and stay in REPEAT.
- Pulse timing: first pulse at edge E, second at E+HOLD_CYCLES, then every REPEAT_CYCLES.
- Release priority: release or conflict seen in the same cycle as a timer expiry suppresses that pulse.
- LOCKOUT: no pulses. Go to IDLE only when db_up=0 and db_down=0.
- IDLE invariant: IDLE is entered only with both buttons released, so every new press produces exactly one first pulse.
- Timer width: clog2(max(HOLD_CYCLES, REPEAT_CYCLES)). Timer never wraps; it is cleared on every state change.
- Reset mid-operation: pulses stop immediately. After release, a still-held button must re-pass sync+debounce, so the first pulse comes DEBOUNCE_CYCLES+2 edges after the first post-release edge.

Test Plan (defaults D=4, H=8, R=3; edge 0 = first sampling edge after raw change):
1. Bounce: btn_up high for 1, 2, 3 cycles separated by 1-cycle lows -> no inc_pulse, db_up stays 0, state IDLE.
2. Short press: btn_up high before edge 0, low before edge 8 -> exactly one inc_pulse, at edge 6. db_up falls at edge 13; the edge-14 expiry is suppressed by release; state returns to IDLE.
3. Long hold: btn_up high edges 0-39, low before edge 40 -> 12 inc_pulses at edges 6, 14, 17, …, 44. repeating=1 from edge 14 to 45. No dec_pulse.
4. Conflict: hold up into REPEAT, then press btn_down -> locked=1 once db_down=1, all pulses stop. Release both -> IDLE. Press down alone -> one dec_pulse D+2 edges later.
5. Simultaneous: btn_up and btn_down rise together from IDLE -> zero pulses, locked=1 until both released.
6. Reset mid-repeat: assert reset=0 during REPEAT with btn_up held -> outputs 0 asynchronously. Deassert with btn_up still high -> next inc_pulse 6 edges after the first post-reset edge, then normal H/R cadence.
